// File: rtl/a2d_intf.sv
// SPI front end for the on-board 8-channel ADC. Each conversion issues the
// channel command twice, 32 idle clocks apart; the result comes from the second frame.
//
// state | meaning
// IDLE  | waiting for strt_cnv; SS_n high, result held
// TX1   | first frame: latch channel into the ADC mux
// GAP   | 32 clocks with SS_n high between frames
// TX2   | second frame: shift in the conversion result
module a2d_intf (
   input  logic        clk,
   input  logic        rst,
   input  logic        strt_cnv,
   input  logic [2:0]  chnnl,
   output logic        cnv_cmplt,
   output logic [11:0] res,
   output logic        a2d_SS_n,
   output logic        SCLK,
   output logic        MOSI,
   input  logic        MISO
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] TX1  = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;
   localparam logic [1:0] TX2  = 2'd3;

   logic [1:0]  state;
   logic [2:0]  chnl_q;
   logic [15:0] tx_shft;
   logic [11:0] rx_shft;
   logic [4:0]  bit_cnt;
   logic [4:0]  div;
   logic [4:0]  gap_cnt;
   logic        sclk_rise;
   logic        sclk_fall;
   logic        frame_done;
   logic        tx_shift_en;
   logic [15:0] cmd_word;

   assign sclk_rise   = ~a2d_SS_n & (div == 5'b01111);
   assign sclk_fall   = ~a2d_SS_n & (div == 5'b11111);
   assign frame_done  = sclk_fall & (bit_cnt == 5'd16);
   // The first SCLK fall comes before any bit is sampled, so it must not shift.
   assign tx_shift_en = sclk_fall & (bit_cnt >= 5'd1) & (bit_cnt <= 5'd15);
   assign cmd_word    = {2'b00, chnl_q, 11'h000};

   assign SCLK = a2d_SS_n | div[4];
   assign MOSI = tx_shft[15];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         chnl_q    <= 3'd0;
         tx_shft   <= 16'h0000;
         rx_shft   <= 12'h000;
         bit_cnt   <= 5'd0;
         div       <= 5'd0;
         gap_cnt   <= 5'd0;
         a2d_SS_n  <= 1'b1;
         cnv_cmplt <= 1'b0;
         res       <= 12'h000;
      end else begin
         if (!a2d_SS_n) div <= div + 5'd1;
         // Only the low 12 bits of each frame are kept; the top nibble shifts out.
         if (sclk_rise) begin
            rx_shft <= {rx_shft[10:0], MISO};
            bit_cnt <= bit_cnt + 5'd1;
         end
         if (tx_shift_en) tx_shft <= {tx_shft[14:0], 1'b0};

         case (state)
            IDLE: begin
               if (strt_cnv) begin
                  chnl_q    <= chnnl;
                  tx_shft   <= {2'b00, chnnl, 11'h000};
                  rx_shft   <= 12'h000;
                  bit_cnt   <= 5'd0;
                  div       <= 5'b10000;
                  a2d_SS_n  <= 1'b0;
                  cnv_cmplt <= 1'b0;
                  state     <= TX1;
               end
            end
            TX1: begin
               if (frame_done) begin
                  a2d_SS_n <= 1'b1;
                  gap_cnt  <= 5'd31;
                  state    <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == 5'd0) begin
                  tx_shft  <= cmd_word;
                  rx_shft  <= 12'h000;
                  bit_cnt  <= 5'd0;
                  div      <= 5'b10000;
                  a2d_SS_n <= 1'b0;
                  state    <= TX2;
               end else begin
                  gap_cnt <= gap_cnt - 5'd1;
               end
            end
            TX2: begin
               if (frame_done) begin
                  a2d_SS_n  <= 1'b1;
                  res       <= rx_shft;
                  cnv_cmplt <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: an ADC model answers each frame, a monitor measures
// frame timing and the MOSI command, and directed conversions are checked.
module tb_a2d_intf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        strt_cnv = 1'b0;
   logic [2:0]  chnnl = 3'd0;
   logic        cnv_cmplt;
   logic [11:0] res;
   logic        a2d_SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [15:0] adc_val [8];
   logic [2:0]  cur_ch = 3'd0;
   logic [11:0] model_res = 12'h000;

   int word_q[$];
   int rise_q[$];
   int len_q[$];
   int gap_q[$];
   int sclk_bad = 0;

   a2d_intf dut (
      .clk       (clk),
      .rst       (rst),
      .strt_cnv  (strt_cnv),
      .chnnl     (chnnl),
      .cnv_cmplt (cnv_cmplt),
      .res       (res),
      .a2d_SS_n  (a2d_SS_n),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   always #5 clk = ~clk;

   // ADC model and frame monitor, evaluated 2 time units after each rising edge.
   // MISO carries a real bit only in the last clock before SCLK rises; otherwise noise.
   logic        prev_ss = 1'b1;
   logic        prev_sclk = 1'b1;
   logic [15:0] mosi_w = 16'h0;
   logic [15:0] adc_data = 16'h0;
   bit          phase = 1'b0;
   int          low_len = 0, hi_len = 0, rises = 0, lc = 0, idx = 0;

   always @(posedge clk) begin
      #2;
      if (rst) phase = 1'b0;
      if (a2d_SS_n === 1'b0) begin
         if (prev_ss) begin
            gap_q.push_back(hi_len);
            low_len = 0; rises = 0; mosi_w = 16'h0; idx = 0; lc = 0;
            adc_data = phase ? adc_val[cur_ch] : 16'($urandom);
            phase = ~phase;
         end
         low_len++;
         if (SCLK && !prev_sclk) begin
            rises++;
            mosi_w = {mosi_w[14:0], MOSI};
            idx++;
         end
         if (!SCLK) lc = prev_sclk ? 0 : lc + 1;
         MISO = (!SCLK && lc == 15 && idx < 16) ? adc_data[15-idx] : 1'($urandom);
      end else begin
         if (!prev_ss) begin
            word_q.push_back(int'(mosi_w));
            rise_q.push_back(rises);
            len_q.push_back(low_len);
            hi_len = 0;
         end
         hi_len++;
         if (SCLK === 1'b0) sclk_bad++;
         MISO = 1'($urandom);
      end
      prev_ss = (a2d_SS_n === 1'b0) ? 1'b0 : 1'b1;
      prev_sclk = (SCLK === 1'b0) ? 1'b0 : 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts a conversion from the current negedge; optionally pulses a second
   // strt_cnv (extra_ch) at observation extra_n. Returns at the completion negedge.
   task automatic run_conv(input logic [2:0] ch, input int extra_n, input logic [2:0] extra_ch);
      int n;
      bit res_moved;
      word_q.delete(); rise_q.delete(); len_q.delete(); gap_q.delete();
      cur_ch = ch;
      chnnl = ch;
      strt_cnv = 1'b1;
      @(negedge clk);
      strt_cnv = 1'b0;
      chnnl = 3'($urandom);
      n = 0;
      res_moved = 0;
      check("cmplt_clear_after_start", cnv_cmplt, 0);
      check("res_held_at_start", res, model_res);
      while (cnv_cmplt !== 1'b1 && n < 1200) begin
         if (n == extra_n) begin
            strt_cnv = 1'b1;
            chnnl = extra_ch;
         end else begin
            strt_cnv = 1'b0;
         end
         @(negedge clk);
         n++;
         if (cnv_cmplt !== 1'b1 && res !== model_res) res_moved = 1;
      end
      strt_cnv = 1'b0;
      check("latency", n, 1088);
      check("res_stable_while_busy", res_moved, 0);
      model_res = adc_val[ch][11:0];
      check("res_value", res, model_res);
      check("frame_count", word_q.size(), 2);
      check("gap_count", gap_q.size(), 2);
      if (word_q.size() == 2 && gap_q.size() == 2) begin
         for (int f = 0; f < 2; f++) begin
            check("mosi_cmd", word_q[f], {16'h0, 2'b00, ch, 11'h000});
            check("sclk_rises", rise_q[f], 16);
            check("ss_low_len", len_q[f], 528);
         end
         check("gap_len", gap_q[1], 32);
      end
   endtask

   initial begin
      int bad;
      for (int i = 0; i < 8; i++) adc_val[i] = 16'($urandom);
      adc_val[3] = 16'hFABC;

      repeat (3) @(negedge clk);
      check("rst_ss_n", a2d_SS_n, 1);
      check("rst_sclk", SCLK, 1);
      check("rst_mosi", MOSI, 0);
      check("rst_cmplt", cnv_cmplt, 0);
      check("rst_res", res, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Channel 3 against the fixed ADC answer
      run_conv(3'd3, -1, 3'd0);
      check("ch3_res_abc", res, 12'hABC);

      // Handshake: result and flag hold until the next start
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         check("hold_cmplt", cnv_cmplt, 1);
         check("hold_res", res, model_res);
      end
      run_conv(3'd6, -1, 3'd0);

      // Start request while busy must not change the channel
      run_conv(3'd1, 299, 3'd5);

      // Start request on the completion edge is ignored
      run_conv(3'd2, 1087, 3'd6);
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (a2d_SS_n !== 1'b1 || cnv_cmplt !== 1'b1) bad++;
      end
      check("strt_at_cmplt_ignored", bad, 0);

      // Reset in the middle of the second frame
      cur_ch = 3'd4;
      chnnl = 3'd4;
      strt_cnv = 1'b1;
      @(negedge clk);
      strt_cnv = 1'b0;
      repeat (699) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_res = 12'h000;
      check("midrst_ss_n", a2d_SS_n, 1);
      check("midrst_sclk", SCLK, 1);
      check("midrst_mosi", MOSI, 0);
      check("midrst_cmplt", cnv_cmplt, 0);
      check("midrst_res", res, 0);
      repeat (3) @(negedge clk);
      run_conv(3'd4, -1, 3'd0);

      // Back-to-back: each start one clock after completion
      for (int c = 0; c < 5; c++) run_conv(3'(c), -1, 3'd0);

      // A few random channels
      for (int r = 0; r < 3; r++) begin
         repeat ($urandom_range(1, 20)) @(negedge clk);
         run_conv(3'($urandom_range(0, 7)), -1, 3'd0);
      end

      check("sclk_high_when_ss_high", sclk_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
